// File: rtl/videogen_pkg.sv
// Shared 720x480@59.94 timing constants, counter widths and colour-stage border sizes.
package videogen_pkg;

   localparam int X_W = 12;
   localparam int Y_W = 11;

   localparam int VG_H_SYNCLEN   = 62;
   localparam int VG_H_BACKPORCH = 60;
   localparam int VG_H_ACTIVE    = 720;
   localparam int VG_H_TOTAL     = 858;
   localparam int VG_V_SYNCLEN   = 6;
   localparam int VG_V_BACKPORCH = 30;
   localparam int VG_V_ACTIVE    = 480;
   localparam int VG_V_TOTAL     = 525;
   localparam int VG_SYNC_DELAY  = 1;

   localparam int VG_OVERSCAN_X = 8;
   localparam int VG_OVERSCAN_Y = 8;
   localparam int VG_BORDER_W   = 2;

   // Bit positions inside the sync/DE delay line, all carried active-high.
   localparam int SB_HS = 0;
   localparam int SB_VS = 1;
   localparam int SB_DE = 2;
   localparam int SB_CS = 3;
`ifdef VIDEOGEN_TIMING_CSYNC_EN
   localparam int SYNC_W = 4;
`else
   localparam int SYNC_W = 3;
`endif

endpackage

// File: rtl/video_sync_delay.sv
// Fixed-depth shift register with async active-low clear; DEPTH=0 is a wire.
module video_sync_delay #(
   parameter int             W     = 1,
   parameter int             DEPTH = 1,
   parameter logic [W-1:0]   RST   = '0
) (
   input  logic         pclk,
   input  logic         reset_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign q = d;
      end else begin : g_pipe
         logic [DEPTH-1:0][W-1:0] pipe;

         always_ff @(posedge pclk or negedge reset_n) begin
            if (!reset_n) begin
               pipe <= {DEPTH{RST}};
            end else begin
               pipe[0] <= d;
               for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
            end
         end

         assign q = pipe[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/videogen_timing.sv
// Free-running raster timing generator feeding the test-pattern colour stage.
// Define VIDEOGEN_TIMING_CSYNC_EN to drive XOR-serrated composite sync on csync_n.
module videogen_timing
   import videogen_pkg::*;
#(
   parameter int H_SYNCLEN   = VG_H_SYNCLEN,
   parameter int H_BACKPORCH = VG_H_BACKPORCH,
   parameter int H_ACTIVE    = VG_H_ACTIVE,
   parameter int H_TOTAL     = VG_H_TOTAL,
   parameter int V_SYNCLEN   = VG_V_SYNCLEN,
   parameter int V_BACKPORCH = VG_V_BACKPORCH,
   parameter int V_ACTIVE    = VG_V_ACTIVE,
   parameter int V_TOTAL     = VG_V_TOTAL,
   parameter int SYNC_DELAY  = VG_SYNC_DELAY
) (
   input  logic           pclk,
   input  logic           reset_n,
   input  logic           enable,
   output logic [X_W-1:0] xpos,
   output logic [Y_W-1:0] ypos,
   output logic           hsync_n,
   output logic           vsync_n,
   output logic           de,
   output logic           csync_n,
   output logic           frame_start
);

   localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
   localparam logic [X_W-1:0] H_SYNC_END = X_W'(H_SYNCLEN);
   localparam logic [X_W-1:0] H_ACT_BEG  = X_W'(H_SYNCLEN + H_BACKPORCH);
   localparam logic [X_W-1:0] H_ACT_END  = X_W'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
   localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
   localparam logic [Y_W-1:0] V_SYNC_END = Y_W'(V_SYNCLEN);
   localparam logic [Y_W-1:0] V_ACT_BEG  = Y_W'(V_SYNCLEN + V_BACKPORCH);
   localparam logic [Y_W-1:0] V_ACT_END  = Y_W'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);

   logic [X_W-1:0]    h_cnt;
   logic [Y_W-1:0]    v_cnt;
   logic              hs_act, vs_act, h_act, v_act;
   logic [SYNC_W-1:0] s1_sync, dly_sync;

   always_comb begin
      hs_act = h_cnt < H_SYNC_END;
      vs_act = v_cnt < V_SYNC_END;
      h_act  = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
      v_act  = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
   end

   // Stage 1: counters plus registered coordinates and active-high sync flags.
   // While disabled the flags are forced idle so the delay line drains inactive.
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         xpos        <= '0;
         ypos        <= '0;
         frame_start <= 1'b0;
         s1_sync     <= '0;
      end else if (!enable) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         xpos        <= '0;
         ypos        <= '0;
         frame_start <= 1'b0;
         s1_sync     <= '0;
      end else begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
         xpos           <= h_act ? h_cnt - H_ACT_BEG : '0;
         ypos           <= v_act ? v_cnt - V_ACT_BEG : '0;
         frame_start    <= (h_cnt == '0) && (v_cnt == '0);
         s1_sync[SB_HS] <= hs_act;
         s1_sync[SB_VS] <= vs_act;
         s1_sync[SB_DE] <= h_act && v_act;
`ifdef VIDEOGEN_TIMING_CSYNC_EN
         s1_sync[SB_CS] <= hs_act ^ vs_act;
`endif
      end
   end

   video_sync_delay #(
      .W     (SYNC_W),
      .DEPTH (SYNC_DELAY),
      .RST   ('0)
   ) u_sync_delay (
      .pclk    (pclk),
      .reset_n (reset_n),
      .d       (s1_sync),
      .q       (dly_sync)
   );

   assign hsync_n = ~dly_sync[SB_HS];
   assign vsync_n = ~dly_sync[SB_VS];
   assign de      = dly_sync[SB_DE];
`ifdef VIDEOGEN_TIMING_CSYNC_EN
   assign csync_n = ~dly_sync[SB_CS];
`else
   assign csync_n = 1'b1;
`endif

   generate
      if (H_SYNCLEN + H_BACKPORCH + H_ACTIVE > H_TOTAL) begin : g_bad_h
         $error("videogen_timing: horizontal sync+backporch+active exceeds H_TOTAL");
      end
      if (V_SYNCLEN + V_BACKPORCH + V_ACTIVE > V_TOTAL) begin : g_bad_v
         $error("videogen_timing: vertical sync+backporch+active exceeds V_TOTAL");
      end
   endgenerate

endmodule

// File: tb/tb_videogen_timing.sv
// Randomised enable/reset stimulus against a frame-position reference model, two raster sizes.
module tb_videogen_timing;

   typedef struct packed {
      logic [11:0] x;
      logic [10:0] y;
      logic        hs_n;
      logic        vs_n;
      logic        de;
      logic        cs_n;
      logic        fs;
   } exp_t;

   typedef struct {
      int hs, hb, ha, ht, vs, vb, va, vt, dly;
   } cfg_t;

   logic pclk = 1'b0;
   logic reset_n, enable;

   logic [11:0] xpos0, xpos1;
   logic [10:0] ypos0, ypos1;
   logic hs0, vs0, de0, cs0, fs0;
   logic hs1, vs1, de1, cs1, fs1;

   always #5 pclk = ~pclk;

   // Full-size 720x480 raster with the default one-cycle sync delay.
   videogen_timing u_std (
      .pclk(pclk), .reset_n(reset_n), .enable(enable),
      .xpos(xpos0), .ypos(ypos0), .hsync_n(hs0), .vsync_n(vs0),
      .de(de0), .csync_n(cs0), .frame_start(fs0)
   );

   // Tiny raster so whole frames (last line, frame period) fit the run; zero sync delay.
   videogen_timing #(
      .H_SYNCLEN(5), .H_BACKPORCH(4), .H_ACTIVE(20), .H_TOTAL(34),
      .V_SYNCLEN(2), .V_BACKPORCH(3), .V_ACTIVE(8), .V_TOTAL(16),
      .SYNC_DELAY(0)
   ) u_small (
      .pclk(pclk), .reset_n(reset_n), .enable(enable),
      .xpos(xpos1), .ypos(ypos1), .hsync_n(hs1), .vsync_n(vs1),
      .de(de1), .csync_n(cs1), .frame_start(fs1)
   );

   exp_t act0, act1;
   assign act0 = {xpos0, ypos0, hs0, vs0, de0, cs0, fs0};
   assign act1 = {xpos1, ypos1, hs1, vs1, de1, cs1, fs1};

   int   errors = 0;
   int   checks = 0;
   exp_t q0[$];
   exp_t q1[$];

   cfg_t       cfg [2];
   int         pos [2];
   logic [3:0] hist[2][4];   // {cs, de, vs, hs} active-high, [0] newest
   exp_t       cur [2];

   task automatic model_reset(input int k);
      pos[k] = 0;
      for (int i = 0; i < 4; i++) hist[k][i] = 4'b0;
      cur[k] = '{x: 12'd0, y: 11'd0, hs_n: 1'b1, vs_n: 1'b1, de: 1'b0, cs_n: 1'b1, fs: 1'b0};
   endtask

   // One clock edge: raster position -> coordinates, sync flags aged by the sync delay.
   task automatic model_step(input int k, input logic en);
      cfg_t c;
      int h, v, h0, v0;
      logic hs, vs, ha, va;
      logic [3:0] a;
      c  = cfg[k];
      h  = pos[k] % c.ht;
      v  = pos[k] / c.ht;
      h0 = c.hs + c.hb;
      v0 = c.vs + c.vb;
      hs = h < c.hs;
      vs = v < c.vs;
      ha = (h >= h0) && (h < h0 + c.ha);
      va = (v >= v0) && (v < v0 + c.va);
      if (en) begin
         cur[k].x  = ha ? 12'(h - h0) : 12'd0;
         cur[k].y  = va ? 11'(v - v0) : 11'd0;
         cur[k].fs = (pos[k] == 0);
         a         = {hs ^ vs, ha && va, vs, hs};
         pos[k]    = (pos[k] + 1) % (c.ht * c.vt);
      end else begin
         cur[k].x  = 12'd0;
         cur[k].y  = 11'd0;
         cur[k].fs = 1'b0;
         a         = 4'b0;
         pos[k]    = 0;
      end
      for (int i = 3; i > 0; i--) hist[k][i] = hist[k][i-1];
      hist[k][0] = a;
      cur[k].hs_n = ~hist[k][c.dly][0];
      cur[k].vs_n = ~hist[k][c.dly][1];
      cur[k].de   =  hist[k][c.dly][2];
`ifdef VIDEOGEN_TIMING_CSYNC_EN
      cur[k].cs_n = ~hist[k][c.dly][3];
`else
      cur[k].cs_n = 1'b1;
`endif
   endtask

   task automatic chk(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         if (errors <= 20)
            $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", nm, k, $time, a, e);
      end
   endtask

   task automatic compare(input int k, input exp_t a, input exp_t e);
      chk("xpos",        k, 32'(a.x),    32'(e.x));
      chk("ypos",        k, 32'(a.y),    32'(e.y));
      chk("hsync_n",     k, 32'(a.hs_n), 32'(e.hs_n));
      chk("vsync_n",     k, 32'(a.vs_n), 32'(e.vs_n));
      chk("de",          k, 32'(a.de),   32'(e.de));
      chk("csync_n",     k, 32'(a.cs_n), 32'(e.cs_n));
      chk("frame_start", k, 32'(a.fs),   32'(e.fs));
   endtask

   // Monitor: outputs are valid every cycle, so pop one expectation per DUT per cycle.
   always @(negedge pclk) begin
      exp_t e;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         compare(0, act0, e);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         compare(1, act1, e);
      end
   end

   // Advance one edge with the current inputs, then apply the next inputs.
   task automatic cycle(input logic nrst, input logic nen);
      @(posedge pclk);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (reset_n) model_step(k, enable);
         else         model_reset(k);
      end
      reset_n = nrst;
      enable  = nen;
      if (!reset_n) begin
         model_reset(0);
         model_reset(1);
      end
      q0.push_back(cur[0]);
      q1.push_back(cur[1]);
   endtask

   initial begin
      int kind, n, len;
      cfg[0] = '{hs: 62, hb: 60, ha: 720, ht: 858, vs: 6, vb: 30, va: 480, vt: 525, dly: 1};
      cfg[1] = '{hs: 5,  hb: 4,  ha: 20,  ht: 34,  vs: 2, vb: 3,  va: 8,   vt: 16,  dly: 0};
      model_reset(0);
      model_reset(1);
      reset_n = 1'b0;
      enable  = 1'b0;

      repeat (5) cycle(1'b0, 1'b0);
      repeat (4) cycle(1'b1, 1'b0);
      // Undisturbed run past the first two active lines of the full-size raster.
      repeat (33000) cycle(1'b1, 1'b1);

      for (int s = 0; s < 60; s++) begin
         kind = $urandom_range(0, 3);
         n    = $urandom_range(1, 20);
         len  = $urandom_range(50, 1200);
         if (kind == 0)      repeat (n % 4 + 1) cycle(1'b0, 1'b1);
         else if (kind == 1) repeat (n) cycle(1'b1, 1'b0);
         repeat (len) cycle(1'b1, 1'b1);
      end

      @(negedge pclk);
      @(negedge pclk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
